// File: rtl/fitness_pkg.sv
// Shared widths and FSM encoding for the truth-table fitness scorer.
// Pure declarations; no timing or flow-control content.
package fitness_pkg;
    localparam int NUM_PATTERNS = 16;
    localparam int IN_W         = 4;
    localparam int OUT_W        = 4;
    localparam int SCORE_W      = 7;
    localparam int TGT_W        = NUM_PATTERNS * OUT_W;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;
endpackage

// File: rtl/fitness_scorer_if.sv
// Run-control, result and evaluated-circuit signals of the fitness scorer.
// master = requester plus circuit under evaluation, slave = scorer.
interface fitness_scorer_if;
    import fitness_pkg::*;

    logic                    start;
    logic [TGT_W-1:0]        target;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic [SCORE_W-1:0]      score;
    logic [NUM_PATTERNS-1:0] fail_mask;

    modport master (
        output start, target, dut_out,
        input  dut_in, busy, done, score, fail_mask
    );

    modport slave (
        input  start, target, dut_out,
        output dut_in, busy, done, score, fail_mask
    );
endinterface

// File: rtl/fitness_scorer_bit_match_count.sv
// Counts agreeing bit positions between two 4-bit words (XNOR popcount).
// Purely combinational, no flow control.
module bit_match_count
    import fitness_pkg::*;
(
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W-1:0] b,
    output logic [2:0]       count
);
    logic [OUT_W-1:0] eq;

    always_comb begin
        eq    = ~(a ^ b);
        count = '0;
        for (int i = 0; i < OUT_W; i++) begin
            count = count + 3'(eq[i]);
        end
    end
endmodule

// File: rtl/fitness_scorer.sv
// Sweeps all 16 input patterns through an external circuit and scores its outputs against a latched truth table.
// Each pattern takes SETTLE_CYCLES+1 cycles; done pulses one cycle after the last sample; start is ignored while a run is active.
module fitness_scorer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int NUM_PATTERNS  = 16
) (
    input  logic            clk,
    input  logic            rst,
    fitness_scorer_if.slave bus
);
    import fitness_pkg::*;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0]  LAST_P      = IN_W'(NUM_PATTERNS - 1);

    state_e                  state_q, state_d;
    logic [TGT_W-1:0]        target_q, target_d;
    logic [IN_W-1:0]         p_q, p_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic [NUM_PATTERNS-1:0] fail_mask_q, fail_mask_d;

    logic [OUT_W-1:0]        exp_slice;
    logic [2:0]              match_cnt;

    // The pattern index doubles as the stimulus, so dut_in moves only when p does.
    assign exp_slice = target_q[{p_q, 2'b00} +: OUT_W];

    bit_match_count u_match (
        .a     (bus.dut_out),
        .b     (exp_slice),
        .count (match_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (p_q == LAST_P) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        target_d    = target_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        fail_mask_d = fail_mask_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d    = bus.target;
                    p_d         = '0;
                    cnt_d       = '0;
                    score_d     = '0;
                    fail_mask_d = '0;
                end
            end
            SETTLE: cnt_d = cnt_q + 1'b1;
            SAMPLE: begin
                // Max total is 16*4 = 64, so the 7-bit accumulator never wraps.
                score_d          = score_q + SCORE_W'(match_cnt);
                fail_mask_d[p_q] = (exp_slice != bus.dut_out);
                if (p_q != LAST_P) begin
                    p_d   = p_q + 1'b1;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SETTLE) || (state_q == SAMPLE);
        bus.done = (state_q == DONE);
    end

    assign bus.dut_in    = p_q;
    assign bus.score     = score_q;
    assign bus.fail_mask = fail_mask_q;
endmodule

// File: tb/tb_fitness_scorer.sv
// Directed bench: feed-through and delayed gate-netlist circuits scored by three scorer instances.
module tb_fitness_scorer;
    import fitness_pkg::*;

    localparam logic [63:0] TBL_FT = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] TBL_B  = 64'h3A5C_0F96_E1B7_248D;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;

    always #5 clk = ~clk;

    fitness_scorer_if if8 ();
    fitness_scorer_if if1 ();
    fitness_scorer_if if40 ();

    fitness_scorer #(.SETTLE_CYCLES(8),  .NUM_PATTERNS(16)) u_s8  (.clk(clk), .rst(rst), .bus(if8.slave));
    fitness_scorer #(.SETTLE_CYCLES(1),  .NUM_PATTERNS(16)) u_s1  (.clk(clk), .rst(rst), .bus(if1.slave));
    fitness_scorer #(.SETTLE_CYCLES(40), .NUM_PATTERNS(16)) u_s40 (.clk(clk), .rst(rst), .bus(if40.slave));

    assign if8.dut_out = if8.dut_in;

    // Two-level gate netlist shared by the 1- and 40-cycle scorers through a selector.
    logic       nl_sel;
    wire  [3:0] nl_a;
    wire        g_and, g_or, g_xor;
    wire  [3:0] nl_y;
    assign nl_a = nl_sel ? if40.dut_in : if1.dut_in;
    assign #50 g_and   = nl_a[0] & nl_a[1];
    assign #50 g_or    = nl_a[2] | nl_a[3];
    assign #50 g_xor   = nl_a[1] ^ nl_a[2];
    assign #50 nl_y[0] = g_and ^ nl_a[3];
    assign #50 nl_y[1] = ~g_or;
    assign #50 nl_y[2] = g_xor | nl_a[0];
    assign #50 nl_y[3] = ~(nl_a[0] ^ nl_a[3]);
    assign if1.dut_out  = nl_y;
    assign if40.dut_out = nl_y;

    function automatic logic [3:0] nl_model(input logic [3:0] a);
        logic [3:0] y;
        y[0] = (a[0] & a[1]) ^ a[3];
        y[1] = ~(a[2] | a[3]);
        y[2] = (a[1] ^ a[2]) | a[0];
        y[3] = ~(a[0] ^ a[3]);
        return y;
    endfunction

    function automatic logic [6:0] ft_score(input logic [63:0] t);
        int s = 0;
        for (int p = 0; p < 16; p++) s += 4 - $countones(4'(p) ^ t[4*p +: 4]);
        return 7'(s);
    endfunction

    function automatic logic [15:0] ft_mask(input logic [63:0] t);
        logic [15:0] m = '0;
        for (int p = 0; p < 16; p++) m[p] = (t[4*p +: 4] != 4'(p));
        return m;
    endfunction

    function automatic logic done_of(input int which);
        case (which)
            0:       return if8.done;
            1:       return if1.done;
            default: return if40.done;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
        end
    endtask

    // Leaves the bench observing cycle 1 (first cycle after acceptance).
    task automatic kick(input int which);
        case (which)
            0:       if8.start = 1'b1;
            1:       if1.start = 1'b1;
            default: if40.start = 1'b1;
        endcase
        tick();
        if8.start  = 1'b0;
        if1.start  = 1'b0;
        if40.start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int which, input int limit);
        while (!done_of(which) && cyc <= limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] nl_tbl;
        logic [6:0]  s_first;
        int          n_done, n_busy;

        rst        = 1'b1;
        if8.start  = 1'b0;  if1.start  = 1'b0;  if40.start  = 1'b0;
        if8.target = '0;    if1.target = '0;    if40.target = '0;
        nl_sel     = 1'b0;
        repeat (3) tick();
        chk("rst_dut_in",    if8.dut_in,    4'h0);
        chk("rst_busy",      if8.busy,      1'b0);
        chk("rst_done",      if8.done,      1'b0);
        chk("rst_score",     if8.score,     7'd0);
        chk("rst_fail_mask", if8.fail_mask, 16'h0);
        chk("rst_busy_s40",  if40.busy,     1'b0);
        rst = 1'b0;
        tick();

        // Test 1: feed-through, matching table
        if8.target = TBL_FT;
        kick(0);
        chk("t1_busy_c1", if8.busy, 1'b1);
        step(8);
        chk("t1_dut_in_c9",  if8.dut_in, 4'h0);
        step(1);
        chk("t1_dut_in_c10", if8.dut_in, 4'h1);
        wait_done(0, 400);
        chk("t1_done_cycle", cyc,           145);
        chk("t1_score",      if8.score,     7'd64);
        chk("t1_fail_mask",  if8.fail_mask, 16'h0000);
        chk("t1_dut_in_end", if8.dut_in,    4'hF);
        chk("t1_busy_done",  if8.busy,      1'b0);
        tick();
        chk("t1_done_pulse", if8.done,      1'b0);
        chk("t1_score_hold", if8.score,     7'd64);

        // Test 2: feed-through against an all-zero table
        if8.target = '0;
        kick(0);
        wait_done(0, 400);
        chk("t2_done_cycle", cyc,           145);
        chk("t2_score",      if8.score,     7'd32);
        chk("t2_fail_mask",  if8.fail_mask, 16'hFFFE);

        // Test 3: delayed gate netlist, too-short and adequate settling
        for (int p = 0; p < 16; p++) nl_tbl[4*p +: 4] = nl_model(4'(p));
        if1.target  = nl_tbl;
        if40.target = nl_tbl;
        nl_sel = 1'b0;
        repeat (20) tick();
        kick(1);
        wait_done(1, 200);
        chk("t3_s1_done_cycle", cyc, 33);
        chk("t3_s1_reduced",    (if1.score < 7'd64), 1'b1);
        nl_sel = 1'b1;
        repeat (20) tick();
        kick(2);
        wait_done(2, 1000);
        chk("t3_s40_done_cycle", cyc,            657);
        chk("t3_s40_score",      if40.score,     7'd64);
        chk("t3_s40_fail_mask",  if40.fail_mask, 16'h0000);

        // Test 4: reset mid-run, reset beats start, then a clean run
        tick();
        if8.target = TBL_FT;
        kick(0);
        step(48);
        chk("t4_score_c49", if8.score, 7'd20);
        chk("t4_busy_c49",  if8.busy,  1'b1);
        rst = 1'b1;
        tick();
        chk("t4_rst_dut_in", if8.dut_in,    4'h0);
        chk("t4_rst_busy",   if8.busy,      1'b0);
        chk("t4_rst_done",   if8.done,      1'b0);
        chk("t4_rst_score",  if8.score,     7'd0);
        chk("t4_rst_mask",   if8.fail_mask, 16'h0);
        if8.start = 1'b1;
        tick();
        chk("t4_rst_priority", if8.busy, 1'b0);
        rst       = 1'b0;
        if8.start = 1'b0;
        tick();
        chk("t4_still_idle", if8.busy, 1'b0);
        kick(0);
        wait_done(0, 400);
        chk("t4_rerun_cycle", cyc,       145);
        chk("t4_rerun_score", if8.score, 7'd64);

        // Test 5: start ignored during SETTLE and DONE; back-to-back runs agree
        tick();
        if8.target = TBL_B;
        kick(0);
        step(4);
        if8.start = 1'b1;
        step(1);
        if8.start = 1'b0;
        chk("t5_busy_after_pulse", if8.busy, 1'b1);
        wait_done(0, 400);
        chk("t5_done_cycle", cyc,           145);
        chk("t5_score",      if8.score,     ft_score(TBL_B));
        chk("t5_fail_mask",  if8.fail_mask, ft_mask(TBL_B));
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (if8.done) n_done++;
            if (if8.busy) n_busy++;
            tick();
        end
        chk("t5_no_extra_done", n_done, 0);
        chk("t5_no_restart",    n_busy, 0);
        kick(0);
        wait_done(0, 400);
        s_first = if8.score;
        chk("t5_run1_score", s_first, ft_score(TBL_B));
        tick();
        kick(0);
        wait_done(0, 400);
        chk("t5_run2_cycle",     cyc,       145);
        chk("t5_run2_vs_run1",   if8.score, s_first);
        chk("t5_run2_fail_mask", if8.fail_mask, ft_mask(TBL_B));

        // Test 6: target changes after acceptance have no effect
        tick();
        if8.target = TBL_FT;
        kick(0);
        step(19);
        if8.target = '0;
        wait_done(0, 400);
        chk("t6_done_cycle", cyc,           145);
        chk("t6_score",      if8.score,     7'd64);
        chk("t6_fail_mask",  if8.fail_mask, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
